// File: rtl/emib_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// emib_port_arbiter_pkg
//   Shared definitions for the EMIB RAM port arbiter: FSM state codes,
//   requester indices, default region split / timeout values, and small
//   index helpers used by the arbiter top level.
// -----------------------------------------------------------------------------
package emib_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_HOLD  = 2'd2,
        ARB_REL   = 2'd3
    } arb_state_e;

    localparam logic [1:0] REQ_MM  = 2'd0;   // MM object write
    localparam logic [1:0] REQ_OPC = 2'd1;   // OPC / FRT-link config write
    localparam logic [1:0] REQ_RD  = 2'd2;   // EMIB read engine

    localparam int FRT_BASE_DEF = 492;
    localparam int TIMEOUT_DEF  = 255;

    // Convert a one-hot grant vector into a requester index.
    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b001:  idx = REQ_MM;
            3'b010:  idx = REQ_OPC;
            3'b100:  idx = REQ_RD;
            default: idx = REQ_MM;
        endcase
        return idx;
    endfunction

    // Round-robin successor of a requester index (2 wraps to 0).
    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            REQ_MM:  nxt = REQ_OPC;
            REQ_OPC: nxt = REQ_RD;
            default: nxt = REQ_MM;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/emib_rr_pick.sv
// -----------------------------------------------------------------------------
// emib_rr_pick
//   Combinational 3-way round-robin picker. The requester at ptr_i has first
//   claim, then the search continues upward modulo 3.
//   req_i  [2:0] : eligible request vector
//   ptr_i  [1:0] : requester index with highest priority
//   gnt_o  [2:0] : one-hot winner, zero when no request
// -----------------------------------------------------------------------------
module emib_rr_pick
    import emib_port_arbiter_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] gnt_o
);

    // Rotated fixed-priority search starting at ptr_i.
    always_comb begin
        gnt_o = 3'b000;
        case (ptr_i)
            REQ_OPC: begin
                if (req_i[1])      gnt_o = 3'b010;
                else if (req_i[2]) gnt_o = 3'b100;
                else if (req_i[0]) gnt_o = 3'b001;
                else               gnt_o = 3'b000;
            end
            REQ_RD: begin
                if (req_i[2])      gnt_o = 3'b100;
                else if (req_i[0]) gnt_o = 3'b001;
                else if (req_i[1]) gnt_o = 3'b010;
                else               gnt_o = 3'b000;
            end
            default: begin
                if (req_i[0])      gnt_o = 3'b001;
                else if (req_i[1]) gnt_o = 3'b010;
                else if (req_i[2]) gnt_o = 3'b100;
                else               gnt_o = 3'b000;
            end
        endcase
    end

endmodule

// File: rtl/emib_port_arbiter.sv
// -----------------------------------------------------------------------------
// emib_port_arbiter
//   Shares the single EMIB RAM port among MM writes (0), OPC config writes (1)
//   and the read engine (2). Round-robin grant, ownership held until the owner
//   drops its request, forced revoke after TIMEOUT idle cycles, and a region
//   split at FRT_BASE (MM below, OPC at/above).
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req / o_gnt           level requests / registered one-hot grant
//   i_mm_*  i_opc_* i_rd_*  per-requester strobes, address, write data
//   o_ram_*                 registered RAM command (addr/wdata zero when idle)
//   i_ram_rdata             RAM read data, valid 1 cycle after o_ram_rd_en
//   o_rd_data / o_rd_valid  registered read return to requester 2
//   o_prot_err / o_timeout  1-cycle event pulses
// -----------------------------------------------------------------------------
module emib_port_arbiter
    import emib_port_arbiter_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 10,
    parameter int FRT_BASE = FRT_BASE_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [2:0]        i_req,
    output logic [2:0]        o_gnt,
    input  logic              i_mm_wr_en,
    input  logic [ADDR_W-1:0] i_mm_addr,
    input  logic [DATA_W-1:0] i_mm_wdata,
    input  logic              i_opc_wr_en,
    input  logic [ADDR_W-1:0] i_opc_addr,
    input  logic [DATA_W-1:0] i_opc_wdata,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_wr_en,
    output logic              o_ram_rd_en,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_prot_err,
    output logic              o_timeout
);

    localparam logic [ADDR_W-1:0] FRT_BASE_A = ADDR_W'(FRT_BASE);
    localparam logic [7:0]        TIMEOUT_C  = 8'(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        owner_q, owner_d;
    logic [2:0]        gnt_q, gnt_d;
    logic [2:0]        blocked_q, blocked_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              prot_err_q, prot_err_d;
    logic              timeout_q, timeout_d;

    logic [2:0]        eligible_s;
    logic [2:0]        pick_s;
    logic              owner_req_s;
    logic              owner_stb_s;
    logic [7:0]        cnt_inc_s;

    // A revoked requester stays ineligible until it has dropped its request.
    assign eligible_s = i_req & ~blocked_q;

    emib_rr_pick u_pick (
        .req_i (eligible_s),
        .ptr_i (ptr_q),
        .gnt_o (pick_s)
    );

    // Select the current owner's request level and strobe.
    always_comb begin
        owner_req_s = 1'b0;
        owner_stb_s = 1'b0;
        case (owner_q)
            REQ_MM: begin
                owner_req_s = i_req[0];
                owner_stb_s = i_mm_wr_en;
            end
            REQ_OPC: begin
                owner_req_s = i_req[1];
                owner_stb_s = i_opc_wr_en;
            end
            REQ_RD: begin
                owner_req_s = i_req[2];
                owner_stb_s = i_rd_en;
            end
            default: begin
                owner_req_s = 1'b0;
                owner_stb_s = 1'b0;
            end
        endcase
    end

    assign cnt_inc_s = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);

    // Next-state, grant, forwarding and event-pulse logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        blocked_d  = blocked_q & i_req;
        addr_d     = '0;
        wdata_d    = '0;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        prot_err_d = 1'b0;
        timeout_d  = 1'b0;
        // Read return pipeline runs independently of arbitration so an
        // in-flight read completes across REL.
        rd_pend_d  = rd_en_q;
        rd_valid_d = rd_pend_q;
        if (rd_pend_q) begin
            rd_data_d = i_ram_rdata;
        end else begin
            rd_data_d = '0;
        end

        case (state_q)
            ARB_IDLE: begin
                if (|eligible_s) begin
                    state_d = ARB_GRANT;
                    gnt_d   = pick_s;
                    owner_d = onehot_to_idx(pick_s);
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                state_d = ARB_HOLD;
                cnt_d   = 8'd0;
            end
            ARB_HOLD: begin
                if (!owner_req_s) begin
                    // Request drop wins over a simultaneous strobe.
                    state_d = ARB_REL;
                    gnt_d   = 3'b000;
                end else if (owner_stb_s) begin
                    cnt_d = 8'd0;
                    case (owner_q)
                        REQ_MM: begin
                            if (i_mm_addr < FRT_BASE_A) begin
                                wr_en_d = 1'b1;
                                addr_d  = i_mm_addr;
                                wdata_d = i_mm_wdata;
                            end else begin
                                prot_err_d = 1'b1;
                            end
                        end
                        REQ_OPC: begin
                            if (i_opc_addr >= FRT_BASE_A) begin
                                wr_en_d = 1'b1;
                                addr_d  = i_opc_addr;
                                wdata_d = i_opc_wdata;
                            end else begin
                                prot_err_d = 1'b1;
                            end
                        end
                        REQ_RD: begin
                            rd_en_d = 1'b1;
                            addr_d  = i_rd_addr;
                        end
                        default: begin
                            wr_en_d = 1'b0;
                        end
                    endcase
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    // Counter reaches the limit on this idle cycle: revoke.
                    cnt_d              = cnt_inc_s;
                    state_d            = ARB_REL;
                    gnt_d              = 3'b000;
                    timeout_d          = 1'b1;
                    blocked_d[owner_q] = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ARB_REL: begin
                ptr_d   = next_ptr(owner_q);
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= 2'd0;
            owner_q    <= 2'd0;
            gnt_q      <= 3'b000;
            blocked_q  <= 3'b000;
            cnt_q      <= 8'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            prot_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            blocked_q  <= blocked_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            rd_pend_q  <= rd_pend_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            prot_err_q <= prot_err_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_ram_addr  = addr_q;
    assign o_ram_wdata = wdata_q;
    assign o_ram_wr_en = wr_en_q;
    assign o_ram_rd_en = rd_en_q;
    assign o_rd_data   = rd_data_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_prot_err  = prot_err_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_emib_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_emib_port_arbiter
//   Directed bench for emib_port_arbiter with a small RAM model.
// -----------------------------------------------------------------------------
module tb_emib_port_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        req;
    logic [2:0]        gnt;
    logic              mm_wr_en, opc_wr_en, rd_en;
    logic [ADDR_W-1:0] mm_addr, opc_addr, rd_addr;
    logic [DATA_W-1:0] mm_wdata, opc_wdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wr_en, ram_rd_en;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, prot_err, timeout;

    logic [DATA_W-1:0] mem [0:1023];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    emib_port_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .o_gnt       (gnt),
        .i_mm_wr_en  (mm_wr_en),
        .i_mm_addr   (mm_addr),
        .i_mm_wdata  (mm_wdata),
        .i_opc_wr_en (opc_wr_en),
        .i_opc_addr  (opc_addr),
        .i_opc_wdata (opc_wdata),
        .i_rd_en     (rd_en),
        .i_rd_addr   (rd_addr),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .o_ram_wr_en (ram_wr_en),
        .o_ram_rd_en (ram_rd_en),
        .i_ram_rdata (ram_rdata),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .o_prot_err  (prot_err),
        .o_timeout   (timeout)
    );

    // RAM model: synchronous write, read data one cycle after the read enable.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_rd_en ? mem[ram_addr] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string tag, input logic [2:0] exp);
        int n;
        n = 0;
        while (gnt == 3'b000 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(gnt), 32'(exp));
    endtask

    task automatic release_to(input string tag, input logic [2:0] new_req);
        int n;
        req = new_req;
        n = 0;
        while (gnt != 3'b000 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(gnt), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10] = 8'h5C;
        ram_rdata = 8'h00;
        rst = 1'b1; req = 3'b000;
        mm_wr_en = 1'b0; opc_wr_en = 1'b0; rd_en = 1'b0;
        mm_addr = '0; opc_addr = '0; rd_addr = '0;
        mm_wdata = '0; opc_wdata = '0;
        tick();
        tick();

        // Reset state
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wr", 32'(ram_wr_en), 32'd0);
        chk("rst_rd", 32'(ram_rd_en), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        chk("rst_err", 32'(prot_err), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        rst = 1'b0;

        // 1: three MM writes, one cycle forwarding latency
        req = 3'b001;
        wait_gnt("t1_gnt", 3'b001);
        mm_wr_en = 1'b1; mm_addr = 10'd5; mm_wdata = 8'hA1;   // dropped in GRANT
        tick();
        chk("t1_grant_drop", 32'(ram_wr_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            mm_addr = 10'(5 + i); mm_wdata = 8'(8'hA1 + i);
            tick();
            chk("t1_wr", 32'(ram_wr_en), 32'd1);
            chk("t1_addr", 32'(ram_addr), 32'(5 + i));
            chk("t1_data", 32'(ram_wdata), 32'(8'hA1 + i));
        end
        mm_wr_en = 1'b0;
        tick();
        chk("t1_wr_off", 32'(ram_wr_en), 32'd0);
        chk("t1_addr_zero", 32'(ram_addr), 32'd0);
        req = 3'b000;
        tick();
        chk("t1_rel_gnt", 32'(gnt), 32'd0);
        tick();
        chk("t1_idle_gnt", 32'(gnt), 32'd0);
        chk("t1_mem5", 32'(mem[5]), 32'hA1);
        chk("t1_mem7", 32'(mem[7]), 32'hA3);

        // 2: round-robin order from reset
        do_reset();
        req = 3'b111;
        wait_gnt("t2_first", 3'b001);
        release_to("t2_rel0", 3'b110);
        wait_gnt("t2_second", 3'b010);
        release_to("t2_rel1", 3'b100);
        wait_gnt("t2_third", 3'b100);
        release_to("t2_rel2", 3'b011);
        req = 3'b111;
        wait_gnt("t2_wrap", 3'b001);
        release_to("t2_rel0b", 3'b110);
        req = 3'b111;
        wait_gnt("t2_ptr1", 3'b010);
        release_to("t2_relx", 3'b000);
        tick();

        // 3: region check
        req = 3'b010;
        wait_gnt("t3_gnt_opc", 3'b010);
        tick();
        opc_wr_en = 1'b1; opc_addr = 10'd491; opc_wdata = 8'h11;
        tick();
        chk("t3_opc491_wr", 32'(ram_wr_en), 32'd0);
        chk("t3_opc491_err", 32'(prot_err), 32'd1);
        opc_addr = 10'd492; opc_wdata = 8'h22;
        tick();
        chk("t3_opc492_wr", 32'(ram_wr_en), 32'd1);
        chk("t3_opc492_err", 32'(prot_err), 32'd0);
        chk("t3_opc492_addr", 32'(ram_addr), 32'd492);
        chk("t3_opc492_data", 32'(ram_wdata), 32'h22);
        opc_wr_en = 1'b0;
        release_to("t3_rel1", 3'b001);
        wait_gnt("t3_gnt_mm", 3'b001);
        tick();
        mm_wr_en = 1'b1; mm_addr = 10'd492; mm_wdata = 8'h33;
        tick();
        chk("t3_mm492_wr", 32'(ram_wr_en), 32'd0);
        chk("t3_mm492_err", 32'(prot_err), 32'd1);
        mm_addr = 10'd491; mm_wdata = 8'h44;
        tick();
        chk("t3_mm491_wr", 32'(ram_wr_en), 32'd1);
        chk("t3_mm491_err", 32'(prot_err), 32'd0);
        mm_wr_en = 1'b0;
        tick();
        chk("t3_err_pulse", 32'(prot_err), 32'd0);
        chk("t3_mem492", 32'(mem[492]), 32'h22);
        chk("t3_mem491", 32'(mem[491]), 32'h44);

        // 4: read with request dropped right after the strobe
        release_to("t3_rel0", 3'b100);
        wait_gnt("t4_gnt", 3'b100);
        tick();
        rd_en = 1'b1; rd_addr = 10'd10;
        tick();
        chk("t4_rd_en", 32'(ram_rd_en), 32'd1);
        chk("t4_rd_addr", 32'(ram_addr), 32'd10);
        rd_en = 1'b0; req = 3'b000;
        tick();
        chk("t4_gnt_rel", 32'(gnt), 32'd0);
        chk("t4_rdv_early", 32'(rd_valid), 32'd0);
        tick();
        chk("t4_rdv", 32'(rd_valid), 32'd1);
        chk("t4_rdata", 32'(rd_data), 32'h5C);
        tick();
        chk("t4_rdv_pulse", 32'(rd_valid), 32'd0);

        // 5: timeout revoke of an idle owner
        req = 3'b010;
        wait_gnt("t5_gnt1", 3'b010);
        req = 3'b011;
        n = 0; seen = 1'b0;
        while (!seen && n < 300) begin
            tick();
            n++;
            if (timeout) seen = 1'b1;
        end
        chk("t5_to_cycle", 32'(n), 32'd256);
        chk("t5_to_gnt", 32'(gnt), 32'd0);
        tick();
        chk("t5_to_pulse", 32'(timeout), 32'd0);
        wait_gnt("t5_gnt0", 3'b001);
        release_to("t5_rel0", 3'b010);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_no_regrant", 32'(gnt), 32'd0);
        end
        req = 3'b000;
        tick();
        req = 3'b010;
        wait_gnt("t5_regrant", 3'b010);
        release_to("t5_rel1", 3'b000);
        tick();

        // 6: reset mid-transfer
        req = 3'b001;
        wait_gnt("t6_gnt", 3'b001);
        tick();
        mm_wr_en = 1'b1; mm_addr = 10'd20; mm_wdata = 8'h44;
        rst = 1'b1;
        tick();
        chk("t6_wr", 32'(ram_wr_en), 32'd0);
        chk("t6_gnt_rst", 32'(gnt), 32'd0);
        chk("t6_addr", 32'(ram_addr), 32'd0);
        chk("t6_wdata", 32'(ram_wdata), 32'd0);
        mm_wr_en = 1'b0; rst = 1'b0; req = 3'b100;
        wait_gnt("t6_gnt_rd", 3'b100);
        tick();
        rd_en = 1'b1; rd_addr = 10'd10;
        tick();
        chk("t6_rd_en", 32'(ram_rd_en), 32'd1);
        rd_en = 1'b0; rst = 1'b1;
        tick();
        chk("t6_rd_en_rst", 32'(ram_rd_en), 32'd0);
        chk("t6_gnt_rst2", 32'(gnt), 32'd0);
        rst = 1'b0; req = 3'b000;
        tick();
        chk("t6_no_rdv", 32'(rd_valid), 32'd0);
        tick();
        chk("t6_no_rdv2", 32'(rd_valid), 32'd0);
        chk("t6_mem20", 32'(mem[20]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
